// File: rtl/tdm_demux8.sv
// Time-division 1-to-LANES demultiplexer: routes serial slot k to lane k and
// presents each completed frame in parallel with a one-cycle valid strobe.
module tdm_demux8 #(
    parameter int unsigned LANES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [LANES-1:0] out,
    output logic             out_valid,
    output logic             frame_err
);

    localparam int unsigned CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [LANES-1:0] shadow, shadow_d;
    logic [LANES-1:0] out_d;
    logic             out_valid_d, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            shadow    <= shadow_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            frame_err <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        shadow_d    = shadow;
        out_d       = out;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid && frame_start) begin
                    shadow_d[0] = din;
                    cnt_d       = CW'(1);
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                if (din_valid) begin
                    // A restart wins even on the final slot: the partial frame is dropped.
                    if (frame_start) begin
                        frame_err_d = 1'b1;
                        shadow_d[0] = din;
                        cnt_d       = CW'(1);
                    end else if (cnt == LAST) begin
                        out_d            = shadow;
                        out_d[LANES-1]   = din;
                        out_valid_d      = 1'b1;
                        cnt_d            = '0;
                        state_d          = IDLE;
                    end else begin
                        shadow_d[cnt] = din;
                        cnt_d         = cnt + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomized and directed bench for tdm_demux8 against a frame-level
// reference model that collects slot bits in a queue.
module tb_tdm_demux8;

    localparam int unsigned LANES = 8;

    logic             clk;
    logic             rst_n;
    logic             din;
    logic             din_valid;
    logic             frame_start;
    logic [LANES-1:0] out;
    logic             out_valid;
    logic             frame_err;

    tdm_demux8 #(.LANES(LANES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .out         (out),
        .out_valid   (out_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      vectors;
    int unsigned      miscompares;
    string            phase;

    // Reference model: bits of the frame in progress, slot 0 first.
    bit               q[$];
    logic [LANES-1:0] exp_out;
    logic             exp_ov;
    logic             exp_fe;
    int unsigned      n_ov;
    int unsigned      n_fe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s/%s: got %h expected %h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_beat(input logic d, input logic dv, input logic fs);
        exp_ov = 1'b0;
        exp_fe = 1'b0;
        if (dv) begin
            if (fs) begin
                if (q.size() > 0) exp_fe = 1'b1;
                q.delete();
                q.push_back(d);
            end else if (q.size() > 0) begin
                q.push_back(d);
                if (q.size() == LANES) begin
                    for (int k = 0; k < LANES; k++) exp_out[k] = q[k];
                    exp_ov = 1'b1;
                    q.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        check("out", 32'(out), 32'(exp_out));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("frame_err", 32'(frame_err), 32'(exp_fe));
        if (out_valid === 1'b1) n_ov++;
        if (frame_err === 1'b1) n_fe++;
    endtask

    task automatic step(input logic d, input logic dv, input logic fs);
        din         = d;
        din_valid   = dv;
        frame_start = fs;
        model_beat(d, dv, fs);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_step();
        step(1'($urandom), 1'b0, 1'($urandom));
    endtask

    task automatic send_frame(input logic [LANES-1:0] val, input bit gapped);
        for (int k = 0; k < LANES; k++) begin
            step(val[k], 1'b1, k == 0);
            if (gapped && (k == 2 || k == 5))
                for (int g = 0; g < 3; g++) idle_step();
        end
    endtask

    // Called just after a rising edge; asserts reset mid-cycle.
    task automatic async_reset();
        din         = 1'($urandom);
        din_valid   = 1'($urandom);
        frame_start = 1'($urandom);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        exp_out = '0;
        exp_ov  = 1'b0;
        exp_fe  = 1'b0;
        check("rst_out", 32'(out), 32'h0);
        check("rst_ov", 32'(out_valid), 32'h0);
        check("rst_fe", 32'(frame_err), 32'h0);
        @(posedge clk);
        #1;
        check_all();
        din_valid   = 1'b0;
        frame_start = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_ov        = 0;
        n_fe        = 0;
        exp_out     = '0;
        exp_ov      = 1'b0;
        exp_fe      = 1'b0;
        rst_n       = 1'b1;
        din         = 1'b0;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        @(posedge clk);
        #1;

        phase = "reset";
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        phase = "single";
        n_ov = 0;
        send_frame(8'h4D, 1'b0);
        check("single_4d", 32'(out), 32'h4D);
        check("single_pulse", 32'(out_valid), 32'h1);
        for (int i = 0; i < 20; i++) idle_step();
        check("single_hold", 32'(out), 32'h4D);
        check("single_npulse", n_ov, 1);

        phase = "gapped";
        async_reset();
        n_ov = 0;
        send_frame(8'h4D, 1'b1);
        check("gapped_4d", 32'(out), 32'h4D);
        for (int i = 0; i < 4; i++) idle_step();
        check("gapped_npulse", n_ov, 1);

        phase = "b2b";
        send_frame(8'hA5, 1'b0);
        check("b2b_a5", 32'(out), 32'hA5);
        send_frame(8'h3C, 1'b0);
        check("b2b_3c", 32'(out), 32'h3C);
        check("b2b_pulse", 32'(out_valid), 32'h1);

        phase = "restart";
        n_ov = 0;
        n_fe = 0;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, k == 0);
        send_frame(8'h81, 1'b0);
        check("restart_81", 32'(out), 32'h81);
        check("restart_nerr", n_fe, 1);
        check("restart_npulse", n_ov, 1);

        phase = "restart_last";
        n_ov = 0;
        n_fe = 0;
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, k == 0);
        step(1'b1, 1'b1, 1'b1);
        check("rlast_err", 32'(frame_err), 32'h1);
        check("rlast_hold", 32'(out), 32'h81);
        for (int k = 1; k < LANES; k++) step(1'b0, 1'b1, 1'b0);
        check("rlast_01", 32'(out), 32'h01);
        check("rlast_nerr", n_fe, 1);

        phase = "stray";
        n_ov = 0;
        n_fe = 0;
        for (int i = 0; i < 10; i++) step(1'($urandom), 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("stray_hold", 32'(out), 32'h01);
        check("stray_nov", n_ov, 0);
        check("stray_nfe", n_fe, 0);

        phase = "midreset";
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, k == 0);
        n_fe = 0;
        async_reset();
        step(1'b1, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b0);
        check("mid_c3", 32'(out), 32'hC3);
        check("mid_nfe", n_fe, 0);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            logic dv;
            logic fs;
            dv = ($urandom_range(0, 3) != 0);
            fs = ($urandom_range(0, 9) == 0);
            step(1'($urandom), dv, fs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
